fourval_sweep_seq: RTL
======================

FOURVAL_SWEEP_SEQ -- requirements
Module: fourval_sweep_seq

Interface
REQ-001 Parameter IN_W, default 4, width of each stimulus bus.
REQ-002 Parameter OUT_W, default 8, width of the spec and impl result buses.
REQ-003 Parameter SETTLE, default 4, cycles to wait after driving a vector before comparing; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a full sweep; sampled in IDLE or DONE only.
REQ-007 in1  output  IN_W  stimulus bus A to both designs under comparison.
REQ-008 in2  output  IN_W  stimulus bus B to both designs under comparison.
REQ-009 spec_out  input  OUT_W  result of the specification design.
REQ-010 impl_out  input  OUT_W  result of the implementation design.
REQ-011 busy  output  1  high from the cycle after start is accepted until the sweep ends.
REQ-012 done  output  1  level; high in DONE until the next start.
REQ-013 err  output  1  one-cycle pulse per mismatching vector.
REQ-014 fail_count  output  4*IN_W+1  count of mismatching vectors in the current sweep.
REQ-015 first_valid  output  1  high once a mismatch has been captured this sweep.
REQ-016 first_in1, first_in2  output  IN_W each  stimulus of the first mismatch.

Function
REQ-017 The SHALL-hold FSM states are IDLE, SETTLE, CHECK and DONE.
REQ-018 In IDLE or DONE, start SHALL clear index, fail_count, first_valid, first_in1, first_in2 and done, and enter SETTLE.
REQ-019 index SHALL be a 4*IN_W-bit register holding 2*IN_W base-4 digits; in1 SHALL map from the upper IN_W digits MSB-first and in2 from the lower IN_W digits, with the least-significant digit driving in2[0] and varying fastest.
REQ-020 Digit encoding SHALL be: 0 -> 1'b0, 1 -> 1'b1, 2 -> 1'bx, 3 -> 1'bz.
REQ-021 in1 and in2 SHALL be driven combinationally from index, so a new vector appears in the same cycle that index changes.
REQ-022 SETTLE SHALL count SETTLE cycles and then enter CHECK.
REQ-023 CHECK SHALL compare using four-valued case inequality (!==); X and Z bits are compared literally.
REQ-024 On a mismatch in CHECK: err pulses, fail_count increments, and if first_valid is low, in1/in2 are captured and first_valid is set.
REQ-025 If index is all-ones in CHECK, the FSM SHALL enter DONE with done set and busy cleared; otherwise index increments and the FSM re-enters SETTLE.
REQ-026 Per-vector latency SHALL be SETTLE+1 cycles, and a full sweep SHALL take 4^(2*IN_W)*(SETTLE+1) cycles.
REQ-027 start SHALL be ignored while busy.
REQ-028 A start in the DONE cycle SHALL restart the sweep without passing through IDLE.
REQ-029 fail_count SHALL never wrap, because its width holds the full vector count.

Reset
REQ-030 Asserting rst_n low, including mid-sweep, SHALL immediately force IDLE.
REQ-031 Reset SHALL set index=0, so in1=0 and in2=0.
REQ-032 Reset SHALL clear busy, done, err, fail_count, first_valid, first_in1 and first_in2 to 0.

Configuration
REQ-033 The macro FOURVAL_SWEEP_XZ_EN SHALL select the sweep alphabet.
REQ-034 With FOURVAL_SWEEP_XZ_EN defined, the sweep SHALL use the four-value alphabet of REQ-019/020.
REQ-035 Without FOURVAL_SWEEP_XZ_EN, digits SHALL be 1 bit wide (values 0/1 only), index SHALL be 2*IN_W bits, and a full sweep SHALL be 2^(2*IN_W) vectors.
REQ-036 fail_count width SHALL be unchanged by FOURVAL_SWEEP_XZ_EN.

Structure
REQ-037 Package fourval_sweep_pkg SHALL hold the FSM state encoding and the digit-to-value constants.
REQ-038 Sub-module fourval_digit_decode SHALL map one digit to one four-valued bit and be instantiated once per stimulus bit.

Verification
REQ-039 Bench: IN_W=1, SETTLE=1, impl tied to spec, pulse start -> 16 vectors in 32 cycles, done=1, fail_count=0, err never pulses.
REQ-040 Bench: IN_W=1, impl = spec except bit0 inverted when in1===1'bx -> fail_count=4, first_in1=x, first_in2=0.
REQ-041 Bench: IN_W=4, SETTLE=4, equal designs -> sweep ends after 327680 cycles with fail_count=0.
REQ-042 Bench: rst_n low at vector 100 mid-sweep -> same cycle IDLE, in1=in2=0, fail_count=0; a new start restarts from vector 0.
REQ-043 Bench: start pulsed while busy -> ignored, no restart, index continues; start held in DONE -> immediate restart with counters cleared.
REQ-044 Bench: build without FOURVAL_SWEEP_XZ_EN, IN_W=2, SETTLE=2 -> 16 vectors in 48 cycles, and no X/Z ever appears on in1/in2.

Source files
------------

// File: rtl/fourval_sweep_pkg.sv
// rtl/fourval_sweep_pkg.sv - shared FSM state encoding and digit constants for the four-value sweep sequencer
// Contents:
//   state_t  : sequencer states IDLE / SETTLE / CHECK / DONE
//   DIG_*    : digit codes for the stimulus alphabet (0, 1, X, Z)
//   DIGIT_W  : bits per index digit; 2 with FOURVAL_SWEEP_XZ_EN defined, 1 otherwise
package fourval_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] DIG_ZERO = 2'd0;
  localparam logic [1:0] DIG_ONE  = 2'd1;
  localparam logic [1:0] DIG_X    = 2'd2;
  localparam logic [1:0] DIG_Z    = 2'd3;

`ifdef FOURVAL_SWEEP_XZ_EN
  localparam int DIGIT_W = 2;
`else
  localparam int DIGIT_W = 1;
`endif

endpackage

// File: rtl/fourval_sweep_seq_if.sv
// rtl/fourval_sweep_seq_if.sv - stimulus/result bus between the sweep sequencer and the two designs under comparison
// Signals:
//   in1, in2  [IN_W]  : stimulus driven by the sequencer to both designs
//   spec_out  [OUT_W] : result of the specification design
//   impl_out  [OUT_W] : result of the implementation design
// Modports:
//   master : sequencer side (drives in1/in2, reads results)
//   slave  : design side (reads in1/in2, drives results)
interface fourval_sweep_seq_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
);

  logic [IN_W-1:0]  in1;
  logic [IN_W-1:0]  in2;
  logic [OUT_W-1:0] spec_out;
  logic [OUT_W-1:0] impl_out;

  modport master (
    output in1,
    output in2,
    input  spec_out,
    input  impl_out
  );

  modport slave (
    input  in1,
    input  in2,
    output spec_out,
    output impl_out
  );

endinterface

// File: rtl/fourval_digit_decode.sv
// rtl/fourval_digit_decode.sv - maps one sweep index digit to one four-valued stimulus bit
// Build option: FOURVAL_SWEEP_XZ_EN enables the X and Z codes (2-bit digits); otherwise digits are 1 bit.
// Ports:
//   digit   [DIGIT_W] in  : one digit of the sweep index
//   bit_out [1]       out : stimulus bit value (0, 1, X or Z)
module fourval_digit_decode
  import fourval_sweep_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic               bit_out
);

  logic [1:0] d2;
  assign d2 = 2'(digit);

  always_comb begin
    bit_out = 1'b0;
    case (d2)
      DIG_ZERO: bit_out = 1'b0;
      DIG_ONE:  bit_out = 1'b1;
`ifdef FOURVAL_SWEEP_XZ_EN
      DIG_X:    bit_out = 1'bx;
      DIG_Z:    bit_out = 1'bz;
`else
      // Binary digits never reach these codes.
      DIG_X, DIG_Z: bit_out = 1'b0;
`endif
      default:  bit_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/fourval_sweep_seq.sv
// rtl/fourval_sweep_seq.sv - exhaustive stimulus sweep comparing a specification design against an implementation
// Build option: FOURVAL_SWEEP_XZ_EN sweeps the 0/1/X/Z alphabet; without it only 0/1 are swept.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request a sweep (honoured in IDLE or DONE only)
//   bus (master)          : in1/in2 stimulus out, spec_out/impl_out results in
//   busy, done            : sweep running / sweep finished (level)
//   err                   : one-cycle pulse on each mismatching vector
//   fail_count            : mismatching vectors in the current sweep
//   first_valid           : a first mismatch has been captured
//   first_in1, first_in2  : stimulus of the first mismatch
module fourval_sweep_seq
  import fourval_sweep_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  fourval_sweep_seq_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [4*IN_W:0]      fail_count,
  output logic                 first_valid,
  output logic [IN_W-1:0]      first_in1,
  output logic [IN_W-1:0]      first_in2
);

  localparam int NBITS = 2 * IN_W;
  localparam int IDX_W = NBITS * DIGIT_W;
  localparam int FC_W  = 4 * IN_W + 1;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [FC_W-1:0]  FC_ONE      = FC_W'(1);

  state_t           state, state_n;
  logic [IDX_W-1:0] index;
  logic [7:0]       settle_cnt, settle_cnt_n;
  logic             clear_sweep, idx_inc, record_fail, mismatch;
  logic [NBITS-1:0] stim;
  logic [OUT_W-1:0] spec_s, impl_s;

  // Bit b of stim is driven by digit b of index: the low IN_W digits feed
  // in2 (digit 0 -> in2[0], fastest-varying), the upper IN_W digits feed in1.
  for (genvar b = 0; b < NBITS; b++) begin : g_dec
    fourval_digit_decode u_dec (
      .digit   (index[b*DIGIT_W +: DIGIT_W]),
      .bit_out (stim[b])
    );
  end

  assign bus.in2 = stim[IN_W-1:0];
  assign bus.in1 = stim[NBITS-1:IN_W];

  // Case inequality so X and Z in the results are compared literally.
  assign spec_s   = bus.spec_out;
  assign impl_s   = bus.impl_out;
  assign mismatch = (spec_s !== impl_s);

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign err  = record_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    clear_sweep  = 1'b0;
    idx_inc      = 1'b0;
    record_fail  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n      = ST_SETTLE;
          settle_cnt_n = 8'd0;
          clear_sweep  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_n      = ST_CHECK;
          settle_cnt_n = 8'd0;
        end else begin
          settle_cnt_n = settle_cnt + 8'd1;
        end
      end
      ST_CHECK: begin
        record_fail = mismatch;
        if (&index) begin
          state_n = ST_DONE;
        end else begin
          idx_inc      = 1'b1;
          settle_cnt_n = 8'd0;
          state_n      = ST_SETTLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index       <= '0;
      settle_cnt  <= 8'd0;
      fail_count  <= '0;
      first_valid <= 1'b0;
      first_in1   <= '0;
      first_in2   <= '0;
    end else begin
      settle_cnt <= settle_cnt_n;
      if (clear_sweep) begin
        index       <= '0;
        fail_count  <= '0;
        first_valid <= 1'b0;
        first_in1   <= '0;
        first_in2   <= '0;
      end else begin
        if (idx_inc) begin
          index <= index + IDX_ONE;
        end
        if (record_fail) begin
          fail_count <= fail_count + FC_ONE;
          if (!first_valid) begin
            first_valid <= 1'b1;
            first_in1   <= bus.in1;
            first_in2   <= bus.in2;
          end
        end
      end
    end
  end

endmodule
